eh2_lsu_ecc_scrub_q: RTL and testbench
======================================

# eh2_lsu_ecc_scrub_q

Correction write-back queue downstream of the LSU ECC decode stage. It captures committed single-bit ECC errors on DCCM loads (address plus corrected lo/hi bank data) and buffers them. When the DCCM write port grants it, the queue writes the corrected words back, one bank word per transfer. This decouples scrubbing from the load pipeline and from store-buffer and DMA traffic.

## Interface
Parameters:
- DEPTH, 2, number of error entries (power of 2, ≥2)
- ADDR_W, 16, DCCM address width (matches DCCM_BITS)
- DATA_W, 32, DCCM bank data width (matches DCCM_DATA_WIDTH)

Ports:
- clk  in  1  core clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- ecc_disable  in  1  when 1, new errors are ignored; queued entries still drain
- flush  in  1  drops all entries synchronously
- in_valid  in  1  committed load with ≥1 single ECC error (DC5 ff stage)
- in_err_lo  in  1  lo bank had single error
- in_err_hi  in  1  hi bank had single error
- in_addr_lo  in  ADDR_W  lo bank word address
- in_addr_hi  in  ADDR_W  hi bank word address
- in_data_lo  in  DATA_W  corrected lo data
- in_data_hi  in  DATA_W  corrected hi data
- wr_valid  out  1  write-back request
- wr_ready  in  1  DCCM port grant (no store-buffer or DMA write this cycle)
- wr_addr  out  ADDR_W  write address
- wr_data  out  DATA_W  corrected data; ECC is generated by the encoder downstream
- wr_hi  out  1  1 = this transfer is hi bank data
- full  out  1  all DEPTH entries valid
- busy  out  1  any entry valid
- overflow  out  1  one-cycle pulse: an error was dropped because the queue was full

## Operation
- Entry fields:
  - valid, lo_pend, hi_pend
  - addr_lo, addr_hi
  - data_lo, data_hi
- Push condition: in_valid & (in_err_lo | in_err_hi) & ~ecc_disable & ~flush.
- On push, the entry at wr_ptr is written with lo_pend = in_err_lo and hi_pend = in_err_hi. wr_ptr then increments modulo DEPTH.
- No address merging. A duplicate address occupies a new entry and is rewritten twice, which is harmless.
- Drain works only on the head entry (rd_ptr):
  - wr_valid = head.valid.
  - wr_hi = ~head.lo_pend. The lo bank drains before the hi bank.
  - wr_addr and wr_data come from the selected bank.
- On wr_valid & wr_ready, the selected pend bit clears.
- When both pend bits of the head are clear, the entry invalidates (pop) in the same cycle and rd_ptr increments modulo DEPTH.
- Occupancy: cnt, width log2(DEPTH)+1.
  - cnt += push; cnt -= pop.
  - full = (cnt == DEPTH); busy = (cnt != 0).
- Push and pop in the same cycle:
  - When not full, both take effect and cnt is unchanged.
  - When full with a pop in the same cycle, the push is accepted. The freed slot is reused and cnt stays at DEPTH.
- Full with no pop: the push is dropped and overflow pulses in the next cycle. Queue state is unchanged.
- flush:
  - Clears all valid and pend bits, pointers and cnt at the next edge.
  - Any same-cycle grant is ignored.
  - flush has priority over push and pop.
- ecc_disable affects only push. Pending entries keep draining.
- rst: identical effect to flush, and also clears overflow.

## Timing
- Reset values:
  - wr_valid = 0, wr_hi = 0, wr_addr = 0, wr_data = 0
  - full = 0, busy = 0, overflow = 0
  - Entry storage is cleared.
- Latency: push at edge N; wr_valid is high in cycle N+1 with the data registered, so there is no input-to-output combinational path.
- Output stability: while wr_valid & ~wr_ready, wr_addr, wr_data and wr_hi stay stable. The request is never withdrawn except by flush or rst.
- Throughput: one bank write per granted cycle.
  - A dual-bank entry needs 2 grants.
  - Back-to-back entries drain with no bubble.
- full and busy are registered, derived from cnt.
- overflow is registered; it is a one-cycle pulse per dropped error.
- wr_ready may be asserted while wr_valid = 0; it has no effect.

## Test plan
- Single lo error, in_addr_lo = 0x0040, data 0xDEADBEEF, wr_ready = 1 → next cycle wr_valid = 1, wr_hi = 0, wr_addr = 0x0040, wr_data = 0xDEADBEEF; busy = 0 the cycle after.
- Dual error (lo 0x0010 / 0x11111111, hi 0x0014 / 0x22222222), wr_ready held 0 for 3 cycles then 1 → outputs stable while stalled; lo is written first, then hi on the next cycle; entry popped after the second grant.
- DEPTH = 2, three pushes on consecutive cycles with wr_ready = 0 → full = 1 after the second push; third dropped, overflow = 1 for exactly one cycle; drain returns only the first two addresses, in order.
- Full queue, push coinciding with the final grant of the head → push accepted; full stays 1; cnt stays 2; FIFO order preserved across pointer wrap.
- flush asserted with 2 entries and wr_ready = 1 on the same cycle → next cycle busy = 0, wr_valid = 0; no further writes.
- ecc_disable = 1 with in_valid pulses while 1 entry is pending → pending entry still drains; no new entries; overflow stays 0.

Source files
------------

// File: rtl/eh2_lsu_ecc_scrub_q.sv
// eh2_lsu_ecc_scrub_q
// Buffers committed single-bit DCCM ECC errors (address + corrected data per
// bank) and writes the corrected words back to the DCCM whenever the write
// port is granted. Lo bank of an entry always drains before its hi bank.
module eh2_lsu_ecc_scrub_q #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ecc_disable,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              in_err_lo,
  input  logic              in_err_hi,
  input  logic [ADDR_W-1:0] in_addr_lo,
  input  logic [ADDR_W-1:0] in_addr_hi,
  input  logic [DATA_W-1:0] in_data_lo,
  input  logic [DATA_W-1:0] in_data_hi,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_hi,
  output logic              full,
  output logic              busy,
  output logic              overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic              valid_r   [DEPTH];
  logic              lo_pend_r [DEPTH];
  logic              hi_pend_r [DEPTH];
  logic [ADDR_W-1:0] addr_lo_r [DEPTH];
  logic [ADDR_W-1:0] addr_hi_r [DEPTH];
  logic [DATA_W-1:0] data_lo_r [DEPTH];
  logic [DATA_W-1:0] data_hi_r [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic              full_r;
  logic              busy_r;
  logic              overflow_r;

  logic              head_valid_s;
  logic              head_sel_hi_s;
  logic              grant_s;
  logic              pop_s;
  logic              push_req_s;
  logic              push_s;
  logic              drop_s;

  // Head-entry view and the push/pop/drop decisions for this cycle.
  always_comb begin
    head_valid_s  = valid_r[rd_ptr_r];
    // Lo bank first; hi is selected only once lo is done (gated so an idle queue shows wr_hi = 0).
    head_sel_hi_s = head_valid_s & ~lo_pend_r[rd_ptr_r];
    grant_s       = head_valid_s & wr_ready & ~flush;
    if (head_sel_hi_s) begin
      pop_s = grant_s;
    end else begin
      pop_s = grant_s & ~hi_pend_r[rd_ptr_r];
    end
    push_req_s = in_valid & (in_err_lo | in_err_hi) & ~ecc_disable & ~flush;
    // A full queue still accepts a push when the head pops in the same cycle.
    push_s     = push_req_s & (~full_r | pop_s);
    drop_s     = push_req_s & full_r & ~pop_s;
  end

  // Next occupancy count; flush empties the queue.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (flush) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (push_s && !pop_s) begin
      cnt_nxt_s = cnt_r + CNT_W'(1);
    end else if (pop_s && !push_s) begin
      cnt_nxt_s = cnt_r - CNT_W'(1);
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Entry storage, pointers, occupancy and the full/busy flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_r[i]   <= 1'b0;
        lo_pend_r[i] <= 1'b0;
        hi_pend_r[i] <= 1'b0;
        addr_lo_r[i] <= {ADDR_W{1'b0}};
        addr_hi_r[i] <= {ADDR_W{1'b0}};
        data_lo_r[i] <= {DATA_W{1'b0}};
        data_hi_r[i] <= {DATA_W{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      full_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_r[i]   <= 1'b0;
        lo_pend_r[i] <= 1'b0;
        hi_pend_r[i] <= 1'b0;
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      full_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      if (grant_s) begin
        if (head_sel_hi_s) begin
          hi_pend_r[rd_ptr_r] <= 1'b0;
        end else begin
          lo_pend_r[rd_ptr_r] <= 1'b0;
        end
      end
      if (pop_s) begin
        valid_r[rd_ptr_r] <= 1'b0;
        rd_ptr_r          <= rd_ptr_r + PTR_W'(1);
      end
      // Written after the pop so a push into the slot just freed wins.
      if (push_s) begin
        valid_r[wr_ptr_r]   <= 1'b1;
        lo_pend_r[wr_ptr_r] <= in_err_lo;
        hi_pend_r[wr_ptr_r] <= in_err_hi;
        addr_lo_r[wr_ptr_r] <= in_addr_lo;
        addr_hi_r[wr_ptr_r] <= in_addr_hi;
        data_lo_r[wr_ptr_r] <= in_data_lo;
        data_hi_r[wr_ptr_r] <= in_data_hi;
        wr_ptr_r            <= wr_ptr_r + PTR_W'(1);
      end
      cnt_r  <= cnt_nxt_s;
      full_r <= (cnt_nxt_s == CNT_W'(DEPTH));
      busy_r <= (cnt_nxt_s != {CNT_W{1'b0}});
    end
  end

  // One-cycle pulse for each error dropped on a full queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= drop_s;
    end
  end

  // Write-back request taken straight from registered head state.
  always_comb begin
    wr_valid = head_valid_s;
    wr_hi    = head_sel_hi_s;
    wr_addr  = {ADDR_W{1'b0}};
    wr_data  = {DATA_W{1'b0}};
    if (!head_valid_s) begin
      wr_addr = {ADDR_W{1'b0}};
      wr_data = {DATA_W{1'b0}};
    end else if (head_sel_hi_s) begin
      wr_addr = addr_hi_r[rd_ptr_r];
      wr_data = data_hi_r[rd_ptr_r];
    end else begin
      wr_addr = addr_lo_r[rd_ptr_r];
      wr_data = data_lo_r[rd_ptr_r];
    end
  end

  assign full     = full_r;
  assign busy     = busy_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_eh2_lsu_ecc_scrub_q.sv
// Directed self-checking bench for eh2_lsu_ecc_scrub_q (DEPTH = 2).
module tb_eh2_lsu_ecc_scrub_q;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              ecc_disable;
  logic              flush;
  logic              in_valid;
  logic              in_err_lo;
  logic              in_err_hi;
  logic [ADDR_W-1:0] in_addr_lo;
  logic [ADDR_W-1:0] in_addr_hi;
  logic [DATA_W-1:0] in_data_lo;
  logic [DATA_W-1:0] in_data_hi;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_hi;
  logic              full;
  logic              busy;
  logic              overflow;

  int n_checks = 0;
  int n_fail   = 0;

  eh2_lsu_ecc_scrub_q #(.DEPTH(2), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .ecc_disable(ecc_disable), .flush(flush),
    .in_valid(in_valid), .in_err_lo(in_err_lo), .in_err_hi(in_err_hi),
    .in_addr_lo(in_addr_lo), .in_addr_hi(in_addr_hi),
    .in_data_lo(in_data_lo), .in_data_hi(in_data_hi),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_hi(wr_hi), .full(full), .busy(busy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs/outputs settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic lo, input logic hi,
                       input logic [15:0] alo, input logic [31:0] dlo,
                       input logic [15:0] ahi, input logic [31:0] dhi);
    in_valid   = v;
    in_err_lo  = lo;
    in_err_hi  = hi;
    in_addr_lo = alo;
    in_data_lo = dlo;
    in_addr_hi = ahi;
    in_data_hi = dhi;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 32'h0, 16'h0000, 32'h0);
  endtask

  initial begin
    rst = 1'b1; ecc_disable = 1'b0; flush = 1'b0; wr_ready = 1'b0;
    idle();
    step(); step();
    rst = 1'b0;
    check("rst_wr_valid", wr_valid, 1'b0);
    check("rst_wr_hi",    wr_hi,    1'b0);
    check("rst_wr_addr",  wr_addr,  16'h0000);
    check("rst_wr_data",  wr_data,  32'h0);
    check("rst_full",     full,     1'b0);
    check("rst_busy",     busy,     1'b0);
    check("rst_overflow", overflow, 1'b0);

    // Single lo error, port granted.
    wr_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 16'h0040, 32'hDEADBEEF, 16'h0044, 32'h0BADF00D);
    step();
    idle();
    check("t1_wr_valid", wr_valid, 1'b1);
    check("t1_wr_hi",    wr_hi,    1'b0);
    check("t1_wr_addr",  wr_addr,  16'h0040);
    check("t1_wr_data",  wr_data,  32'hDEADBEEF);
    check("t1_busy",     busy,     1'b1);
    step();
    check("t1_busy_after",  busy,     1'b0);
    check("t1_valid_after", wr_valid, 1'b0);

    // Dual error, 3 stalled cycles then granted.
    wr_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 16'h0010, 32'h11111111, 16'h0014, 32'h22222222);
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      check("t2_stall_valid", wr_valid, 1'b1);
      check("t2_stall_hi",    wr_hi,    1'b0);
      check("t2_stall_addr",  wr_addr,  16'h0010);
      check("t2_stall_data",  wr_data,  32'h11111111);
      step();
    end
    wr_ready = 1'b1;
    check("t2_lo_addr", wr_addr, 16'h0010);
    step();
    check("t2_hi_valid", wr_valid, 1'b1);
    check("t2_hi_sel",   wr_hi,    1'b1);
    check("t2_hi_addr",  wr_addr,  16'h0014);
    check("t2_hi_data",  wr_data,  32'h22222222);
    check("t2_hi_busy",  busy,     1'b1);
    step();
    check("t2_pop_busy",  busy,     1'b0);
    check("t2_pop_valid", wr_valid, 1'b0);

    // Three pushes into DEPTH=2 with no grant: third dropped.
    wr_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 16'h0100, 32'hA0A0A0A0, 16'h0, 32'h0);
    step();
    check("t3_full_1", full, 1'b0);
    check("t3_busy_1", busy, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 16'h0200, 32'hB0B0B0B0, 16'h0, 32'h0);
    step();
    check("t3_full_2", full,     1'b1);
    check("t3_ovf_2",  overflow, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 16'h0300, 32'hC0C0C0C0, 16'h0, 32'h0);
    step();
    idle();
    check("t3_ovf_pulse", overflow, 1'b1);
    check("t3_full_3",    full,     1'b1);
    step();
    check("t3_ovf_clear", overflow, 1'b0);
    wr_ready = 1'b1;
    check("t3_drain0_addr", wr_addr, 16'h0100);
    check("t3_drain0_data", wr_data, 32'hA0A0A0A0);
    step();
    check("t3_drain1_addr", wr_addr, 16'h0200);
    check("t3_drain1_data", wr_data, 32'hB0B0B0B0);
    check("t3_drain1_full", full,    1'b0);
    step();
    check("t3_empty_busy",  busy,     1'b0);
    check("t3_empty_valid", wr_valid, 1'b0);

    // Full queue, push on the head's final grant.
    wr_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 16'h0000, 32'h0, 16'h0500, 32'h55555555);
    step();
    drive(1'b1, 1'b1, 1'b0, 16'h0600, 32'h66666666, 16'h0, 32'h0);
    step();
    check("t4_full", full, 1'b1);
    check("t4_head_hi",   wr_hi,   1'b1);
    check("t4_head_addr", wr_addr, 16'h0500);
    drive(1'b1, 1'b1, 1'b0, 16'h0700, 32'h77777777, 16'h0, 32'h0);
    wr_ready = 1'b1;
    step();
    idle();
    wr_ready = 1'b0;
    check("t4_full_kept", full,     1'b1);
    check("t4_no_ovf",    overflow, 1'b0);
    check("t4_e_addr",    wr_addr,  16'h0600);
    check("t4_e_hi",      wr_hi,    1'b0);
    wr_ready = 1'b1;
    step();
    check("t4_f_addr", wr_addr, 16'h0700);
    check("t4_f_data", wr_data, 32'h77777777);
    check("t4_f_full", full,    1'b0);
    step();
    check("t4_empty", busy, 1'b0);

    // Flush with two entries and a same-cycle grant.
    wr_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 16'h0800, 32'h88888888, 16'h0, 32'h0);
    step();
    drive(1'b1, 1'b1, 1'b1, 16'h0810, 32'h81818181, 16'h0814, 32'h82828282);
    step();
    idle();
    check("t5_pre_full", full, 1'b1);
    wr_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t5_busy",  busy,     1'b0);
    check("t5_valid", wr_valid, 1'b0);
    check("t5_full",  full,     1'b0);
    step();
    check("t5_still_idle", wr_valid, 1'b0);

    // ecc_disable blocks new errors while a pending entry drains.
    wr_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 16'h0900, 32'h99999999, 16'h0, 32'h0);
    step();
    ecc_disable = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 16'h0A00, 32'hAAAAAAAA, 16'h0A04, 32'hABABABAB);
    step();
    step();
    check("t6_busy",  busy,     1'b1);
    check("t6_full",  full,     1'b0);
    check("t6_ovf",   overflow, 1'b0);
    check("t6_addr",  wr_addr,  16'h0900);
    wr_ready = 1'b1;
    step();
    check("t6_drained", busy,     1'b0);
    check("t6_ovf2",    overflow, 1'b0);
    step();
    idle();
    ecc_disable = 1'b0;
    check("t6_no_new", wr_valid, 1'b0);
    step();
    check("t6_no_new2", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
